// File: rtl/draw_pkg.sv
// Shared types and constants for the paint datapath shape blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package draw_pkg;

  // Rasteriser control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Shape drawing modes.
  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  // Default VGA framebuffer dimensions shared by paint blocks.
  localparam int SCREEN_X_MAX = 160;
  localparam int SCREEN_Y_MAX = 120;

endpackage

// File: rtl/scan_2d.sv
// Raster col/row scanner: col 0..w-1 per row, optional jump from col 0 to col w-1.
// Latency: counters update on the edge after clear/advance; nxt_* and last are combinational.
// Backpressure: none; advances only when the owner pulses advance.
module scan_2d #(
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  input  logic          jump,
  input  logic [SW-1:0] w,
  input  logic [SW-1:0] h,
  output logic [SW-1:0] row,
  output logic [SW-1:0] nxt_col,
  output logic [SW-1:0] nxt_row,
  output logic          last
);

  logic [SW-1:0] col;
  logic          col_end;
  logic          row_end;

  assign col_end = (col == w - SW'(1));
  assign row_end = (row == h - SW'(1));
  assign last    = col_end && row_end;

  // Next scan position: wrap at the row end, or skip a row interior when jumping.
  always_comb begin
    nxt_col = col + SW'(1);
    nxt_row = row;
    if (col_end) begin
      nxt_col = '0;
      nxt_row = row + SW'(1);
    end else if (jump && (col == '0)) begin
      nxt_col = w - SW'(1);
    end
  end

  // Position registers; clear has priority so a new shape always starts at (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      col <= nxt_col;
      row <= nxt_row;
    end
  end

endmodule

// File: rtl/draw_rect.sv
// Rectangle rasteriser: one candidate pixel per clock, fill or outline, clipped to the screen.
// Latency: start accepted at edge N gives first candidate in cycle N+1; done one cycle after the last.
// Backpressure: none downstream; upstream start only taken while ready (IDLE), abort cancels a draw.
module draw_rect
  import draw_pkg::*;
#(
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int SW    = 8,
  parameter int CW    = 3,
  parameter int X_MAX = SCREEN_X_MAX,
  parameter int Y_MAX = SCREEN_Y_MAX
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [SW-1:0] w,
  input  logic [SW-1:0] h,
  input  logic [CW-1:0] color,
  input  logic          mode,
  output logic          ready,
  output logic          plot,
  output logic [XW-1:0] plot_x,
  output logic [YW-1:0] plot_y,
  output logic [CW-1:0] plot_color,
  output logic          done
);

  // Sums carry one extra bit so origin+offset wrap-around reads as off-screen.
  localparam int XSW = ((XW > SW) ? XW : SW) + 1;
  localparam int YSW = ((YW > SW) ? YW : SW) + 1;
  localparam logic [XSW-1:0] X_LIM = XSW'(X_MAX);
  localparam logic [YSW-1:0] Y_LIM = YSW'(Y_MAX);

  state_t        state, state_nxt;
  logic          accept, advance, empty, jump, last;
  logic [XW-1:0] x_l, base_x;
  logic [YW-1:0] y_l, base_y;
  logic [SW-1:0] w_l, h_l, row, nxt_col, nxt_row, off_c, off_r;
  logic          mode_l;
  logic [XSW-1:0] sum_x;
  logic [YSW-1:0] sum_y;
  logic          in_screen;

  assign ready = (state == IDLE);
  assign empty = (w == '0) || (h == '0);
  assign jump  = (mode_l == MODE_OUTLINE) && (row != '0) && (row != h_l - SW'(1));

  scan_2d #(.SW(SW)) u_scan (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .advance (advance),
    .jump    (jump),
    .w       (w_l),
    .h       (h_l),
    .row     (row),
    .nxt_col (nxt_col),
    .nxt_row (nxt_row),
    .last    (last)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state plus accept/advance strobes; abort wins over completion.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = empty ? FIN : DRAW;
        end
      end
      DRAW: begin
        if (abort)     state_nxt = IDLE;
        else if (last) state_nxt = FIN;
        else           advance   = 1'b1;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next candidate: on accept it is the raw origin, otherwise latched origin plus next offset.
  always_comb begin
    base_x = accept ? x0 : x_l;
    base_y = accept ? y0 : y_l;
    off_c  = accept ? '0 : nxt_col;
    off_r  = accept ? '0 : nxt_row;
  end

  assign sum_x     = XSW'(base_x) + XSW'(off_c);
  assign sum_y     = YSW'(base_y) + YSW'(off_r);
  assign in_screen = (sum_x < X_LIM) && (sum_y < Y_LIM);

  // Shape parameters captured at accept and held for the whole draw.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_l    <= '0;
      y_l    <= '0;
      w_l    <= '0;
      h_l    <= '0;
      mode_l <= MODE_FILL;
    end else if (accept) begin
      x_l    <= x0;
      y_l    <= y0;
      w_l    <= w;
      h_l    <= h;
      mode_l <= mode;
    end
  end

  // Registered pixel outputs; plot and coordinates update together, done marks entry to FIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      plot       <= 1'b0;
      plot_x     <= '0;
      plot_y     <= '0;
      plot_color <= '0;
      done       <= 1'b0;
    end else begin
      done <= (state_nxt == FIN);
      if (accept || advance) begin
        plot   <= in_screen && !(accept && empty);
        plot_x <= sum_x[XW-1:0];
        plot_y <= sum_y[YW-1:0];
      end else begin
        plot <= 1'b0;
      end
      if (accept) plot_color <= color;
    end
  end

endmodule

// File: tb/tb_draw_rect.sv
// Self-checking bench for draw_rect: table of shapes plus abort/reset/busy-start sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_draw_rect;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] x0 = '0;
  logic [6:0] y0 = '0;
  logic [7:0] w = '0;
  logic [7:0] h = '0;
  logic [2:0] color = '0;
  logic       mode = 1'b0;
  logic       ready, plot, done;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_color;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  draw_rect dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .x0         (x0),
    .y0         (y0),
    .w          (w),
    .h          (h),
    .color      (color),
    .mode       (mode),
    .ready      (ready),
    .plot       (plot),
    .plot_x     (plot_x),
    .plot_y     (plot_y),
    .plot_color (plot_color),
    .done       (done)
  );

  typedef struct {
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] w;
    logic [7:0] h;
    logic [2:0] color;
    logic       mode;
    int         cyc;
    int         plots;
    int         sx;
    int         sy;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_shape(input logic [7:0] ax, input logic [6:0] ay, input logic [7:0] aw,
                             input logic [7:0] ah, input logic [2:0] ac, input logic am);
    x0 = ax; y0 = ay; w = aw; h = ah; color = ac; mode = am;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n, plots, sx, sy, cbad;
    n = 0; plots = 0; sx = 0; sy = 0; cbad = 0;
    @(negedge clk);
    drive_shape(v.x0, v.y0, v.w, v.h, v.color, v.mode);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && n < 300) begin
      if (plot === 1'b1) begin
        plots++;
        sx += int'(plot_x);
        sy += int'(plot_y);
        if (plot_color !== v.color) cbad++;
      end
      n++;
      @(negedge clk);
    end
    check($sformatf("v%0d draw_cycles", idx), n, v.cyc);
    check($sformatf("v%0d plot_count", idx), plots, v.plots);
    check($sformatf("v%0d sum_x", idx), sx, v.sx);
    check($sformatf("v%0d sum_y", idx), sy, v.sy);
    check($sformatf("v%0d bad_color", idx), cbad, 0);
    check($sformatf("v%0d ready_in_fin", idx), ready, 0);
    @(negedge clk);
    check($sformatf("v%0d done_width", idx), done, 0);
    check($sformatf("v%0d ready_after_done", idx), ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, plots, dones;

    //        x0    y0    w     h     col   mode  cyc plots sx   sy
    vecs[0]  = '{8'd10,  7'd20,  8'd3,  8'd2, 3'd5, 1'b0,  6,  6,  66, 123};
    vecs[1]  = '{8'd0,   7'd0,   8'd4,  8'd4, 3'd3, 1'b1, 12, 12,  18,  18};
    vecs[2]  = '{8'd158, 7'd119, 8'd4,  8'd2, 3'd7, 1'b0,  8,  2, 317, 238};
    vecs[3]  = '{8'd250, 7'd0,   8'd10, 8'd1, 3'd1, 1'b0, 10,  0,   0,   0};
    vecs[4]  = '{8'd5,   7'd5,   8'd0,  8'd7, 3'd2, 1'b0,  0,  0,   0,   0};
    vecs[5]  = '{8'd5,   7'd6,   8'd1,  8'd1, 3'd2, 1'b1,  1,  1,   5,   6};
    vecs[6]  = '{8'd2,   7'd3,   8'd1,  8'd3, 3'd6, 1'b1,  3,  3,   6,  12};
    vecs[7]  = '{8'd0,   7'd0,   8'd3,  8'd0, 3'd4, 1'b0,  0,  0,   0,   0};
    vecs[8]  = '{8'd10,  7'd10,  8'd5,  8'd1, 3'd1, 1'b1,  5,  5,  60,  50};
    vecs[9]  = '{8'd100, 7'd50,  8'd3,  8'd3, 3'd4, 1'b1,  8,  8, 808, 408};
    vecs[10] = '{8'd159, 7'd118, 8'd2,  8'd3, 3'd3, 1'b1,  6,  2, 318, 237};

    // Reset state while reset is held.
    @(negedge clk);
    @(negedge clk);
    check("rst ready", ready, 1);
    check("rst plot", plot, 0);
    check("rst done", done, 0);
    check("rst plot_x", plot_x, 0);
    check("rst plot_y", plot_y, 0);
    check("rst plot_color", plot_color, 0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Abort on the 3rd DRAW cycle of a 5x5 fill, then an immediate new start.
    @(negedge clk);
    drive_shape(8'd0, 7'd0, 8'd5, 8'd5, 3'd2, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    plots = 0;
    for (int i = 0; i < 3; i++) begin
      if (plot === 1'b1) plots++;
      if (i == 2) begin
        check("abort last_x", plot_x, 2);
        abort = 1'b1;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    check("abort plots", plots, 3);
    check("abort ready", ready, 1);
    check("abort no_done", done, 0);
    check("abort plot_off", plot, 0);
    drive_shape(8'd7, 7'd7, 8'd1, 8'd1, 3'd1, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_abort plot", plot, 1);
    check("post_abort x", plot_x, 7);
    check("post_abort y", plot_y, 7);
    @(negedge clk);
    check("post_abort done", done, 1);
    @(negedge clk);

    // Start pulses while busy are ignored and not queued.
    drive_shape(8'd20, 7'd20, 8'd4, 8'd1, 3'd6, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; plots = 0;
    while (done !== 1'b1 && n < 50) begin
      if (plot === 1'b1) plots++;
      if (n == 1) begin
        drive_shape(8'd0, 7'd0, 8'd9, 8'd9, 3'd1, 1'b0);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b1;
    check("busy cycles", n, 4);
    check("busy plots", plots, 4);
    @(negedge clk);
    start = 1'b0;
    plots = 0;
    for (int i = 0; i < 6; i++) begin
      if (plot === 1'b1) plots++;
      @(negedge clk);
    end
    check("busy not_queued", plots, 0);

    // Reset pulsed mid-draw drops outputs at once and suppresses done.
    drive_shape(8'd30, 7'd30, 8'd5, 8'd5, 3'd3, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset plot", plot, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_reset plot", plot, 0);
    check("mid_reset done", done, 0);
    check("mid_reset ready", ready, 1);
    check("mid_reset plot_x", plot_x, 0);
    @(negedge clk);
    reset = 1'b0;
    plots = 0; dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (plot === 1'b1) plots++;
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    check("post_reset plots", plots, 0);
    check("post_reset dones", dones, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
